sprite_line_scheduler: RTL
==========================

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 Parameter ELEMENT, default 5: width of the sprite-memory element index.
REQ-002 Parameter SLOTS, default 32: number of sprite table slots.
REQ-003 Parameter MAX_LINE, default 4: maximum sprites drawn on one line.
REQ-004 Parameter SIZE, default 20: sprite edge in pixels (square).
REQ-005 Parameter H_ACTIVE, default 640; V_TOTAL, default 525: the line where the scan starts, and the vertical wrap.
REQ-006 clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pixel_x  input  11  current horizontal pixel from the VGA sync.
REQ-009 pixel_y  input  10  current vertical pixel from the VGA sync.
REQ-010 wr_en  input  1  sprite table write strobe.
REQ-011 wr_slot  input  log2(SLOTS)  slot being written.
REQ-012 wr_data  input  21+ELEMENT  fields, msb first: active(1), x(10), y(10), element(ELEMENT).
REQ-013 ready  output  1  a sprite pixel is valid this cycle.
REQ-014 element  output  ELEMENT  sprite-memory element index of the winning sprite.
REQ-015 address  output  10  pixel address inside the sprite, equal to row*SIZE+col.
REQ-016 overflow  output  1  sticky flag: more than MAX_LINE sprites hit one line.

Function
REQ-017 wr_en SHALL write wr_data into wr_slot at the clock edge; a write that lands on the slot being scanned in the same cycle SHALL be seen by the scan as the old value.
REQ-018 FSM states SHALL be IDLE, SCAN and WAIT.
- IDLE -> SCAN when pixel_x == H_ACTIVE.
- SCAN reads one slot per cycle, slot 0 to SLOTS-1, then goes to WAIT.
- WAIT -> IDLE when pixel_x == 0, which swaps the buffers.
REQ-019 The scan SHALL target y_next = pixel_y+1, or 0 when pixel_y == V_TOTAL-1.
REQ-020 A slot SHALL hit when active == 1 and y <= y_next <= y+SIZE-1, with the comparison done at 11 bits.
REQ-021 Hits SHALL be stored in the shadow line buffer in ascending slot order; each entry holds x, row = y_next-y, and element.
REQ-022 A hit that arrives when the shadow buffer already holds MAX_LINE entries SHALL be dropped and SHALL set overflow.
- overflow is cleared only by reset.
REQ-023 The shadow buffer SHALL be cleared on entry to SCAN; on the swap it SHALL become the active buffer.
REQ-024 During every cycle, the active buffer entries with x <= pixel_x <= x+SIZE-1 SHALL compete, and the lowest buffer index (lowest slot number) wins.
REQ-025 Output latency SHALL be 1 clk: on the next edge, ready=1, element=winner element, address=row*SIZE+(pixel_x-x).
REQ-026 With no winner, ready SHALL be 0 and element/address SHALL hold their last values.
REQ-027 A sprite with x+SIZE > 1023 or y+SIZE > 1023 SHALL be clipped with no wrap-around, because all compares are 11-bit.
REQ-028 A SCAN still in progress at pixel_x == 0 SHALL be aborted; no swap SHALL occur, the active buffer is retained, and the FSM goes to IDLE.
REQ-029 SLOTS SHALL be no more than the horizontal blanking length in clk cycles; this is a documented integration constraint.

Reset
REQ-030 On reset, the following SHALL be set to 0 on the next edge, whatever the FSM state:
- ready, element, address, overflow;
- every table active bit;
- both buffer entry counts.
- The FSM SHALL go to IDLE.
REQ-031 After reset deasserts, ready SHALL stay 0 until the first completed SCAN has been swapped in.

Structure
REQ-032 Field widths, field offsets within wr_data, and the FSM state encodings SHALL live in the shared console constants package.
REQ-033 The sprite table SHALL be a sub-module, sprite_table: SLOTS registers, one write port, one indexed read port.
REQ-034 Line buffers, the FSM and the priority/address datapath SHALL stay in sprite_line_scheduler.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Slot 3 = {1,x=100,y=50,el=7}, line y=50, pixel_x=105 -> one cycle later ready=1, element=7, address=5; pixel_x=120 -> ready=0.
- Slots 2 and 9 overlap at x=200 on the same line -> element of slot 2 output; address uses slot 2 row/col.
- Six active sprites on line 80 -> first four by slot order drawn, slots 5..6 absent, overflow=1 and stays 1 across frames.
- Sprite y=520, pixel_y=524 -> scan targets line 0, so a sprite y=0 is drawn on line 0 and the y=520 sprite is not.
- Write slot k in the same cycle the scan reads k -> the current line uses the old value, and the next line uses the new value.
- Reset asserted mid-SCAN -> next edge all outputs 0, FSM IDLE; ready remains 0 for the rest of that line.

Source files
------------

// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants for the sprite line scheduler: sprite word layout,
// compare widths and FSM state encodings.
package sprite_line_scheduler_pkg;

    localparam int COORD_W     = 10;
    localparam int CMP_W       = 11;
    localparam int PIX_X_W     = 11;
    localparam int PIX_Y_W     = 10;
    localparam int ADDR_W      = 10;
    localparam int WORD_BASE_W = 2 * COORD_W + 1;

    // Field offsets measured from the top of the element field (element sits at bit 0).
    localparam int Y_OFS   = 0;
    localparam int X_OFS   = COORD_W;
    localparam int ACT_OFS = 2 * COORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2
    } scan_state_e;

    function automatic int word_width(input int element_w);
        return WORD_BASE_W + element_w;
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_table.sv
// Sprite attribute table: one write port, one combinational indexed read port,
// so a same-edge write is observed by the reader as the old contents.
module sprite_table
    import sprite_line_scheduler_pkg::*;
#(
    parameter int ELEMENT = 5,
    parameter int SLOTS   = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             wr_en_i,
    input  logic [$clog2(SLOTS)-1:0]         wr_slot_i,
    input  logic [WORD_BASE_W+ELEMENT-1:0]   wr_data_i,
    input  logic [$clog2(SLOTS)-1:0]         rd_slot_i,
    output logic [WORD_BASE_W+ELEMENT-1:0]   rd_data_o
);
    localparam int WORD_W  = word_width(ELEMENT);
    localparam int ACT_BIT = ELEMENT + ACT_OFS;

    logic [WORD_W-1:0] mem_q [SLOTS];

    // Only the active bits need clearing; other fields are don't-care while inactive.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                mem_q[i][ACT_BIT] <= 1'b0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_slot_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_slot_i];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite scheduler: scans the sprite table during blanking into a shadow
// line buffer, swaps it in at the line start, and emits the winning sprite pixel.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter int ELEMENT  = 5,
    parameter int SLOTS    = 32,
    parameter int MAX_LINE = 4,
    parameter int SIZE     = 20,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [PIX_X_W-1:0]             pixel_x,
    input  logic [PIX_Y_W-1:0]             pixel_y,
    input  logic                           wr_en,
    input  logic [$clog2(SLOTS)-1:0]       wr_slot,
    input  logic [WORD_BASE_W+ELEMENT-1:0] wr_data,
    output logic                           ready,
    output logic [ELEMENT-1:0]             element,
    output logic [ADDR_W-1:0]              address,
    output logic                           overflow
);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int WORD_W = word_width(ELEMENT);
    localparam int CNT_W  = $clog2(MAX_LINE + 1);
    localparam int IDX_W  = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

    scan_state_e         state_q;
    logic [SLOT_W-1:0]   scan_idx_q;
    logic [CMP_W-1:0]    y_next_q;
    logic                overflow_q;

    logic [COORD_W-1:0]  shd_x_q   [MAX_LINE];
    logic [COORD_W-1:0]  shd_row_q [MAX_LINE];
    logic [ELEMENT-1:0]  shd_el_q  [MAX_LINE];
    logic [CNT_W-1:0]    shd_cnt_q;
    logic [COORD_W-1:0]  act_x_q   [MAX_LINE];
    logic [COORD_W-1:0]  act_row_q [MAX_LINE];
    logic [ELEMENT-1:0]  act_el_q  [MAX_LINE];
    logic [CNT_W-1:0]    act_cnt_q;

    logic                ready_q;
    logic [ELEMENT-1:0]  element_q;
    logic [ADDR_W-1:0]   address_q;

    logic [WORD_W-1:0]   rd_data;
    logic                rd_active;
    logic [COORD_W-1:0]  rd_x;
    logic [COORD_W-1:0]  rd_y;
    logic [ELEMENT-1:0]  rd_el;
    logic [CMP_W-1:0]    y_top;
    logic [CMP_W-1:0]    y_bot;
    logic [CMP_W-1:0]    y_target;
    logic                scan_hit;
    logic [COORD_W-1:0]  scan_row;

    sprite_table #(
        .ELEMENT (ELEMENT),
        .SLOTS   (SLOTS)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_en),
        .wr_slot_i (wr_slot),
        .wr_data_i (wr_data),
        .rd_slot_i (scan_idx_q),
        .rd_data_o (rd_data)
    );

    assign rd_active = rd_data[ELEMENT + ACT_OFS];
    assign rd_x      = rd_data[ELEMENT + X_OFS +: COORD_W];
    assign rd_y      = rd_data[ELEMENT + Y_OFS +: COORD_W];
    assign rd_el     = rd_data[ELEMENT-1:0];

    // 11-bit compares keep sprites near 1023 clipped instead of wrapping to the top.
    assign y_top    = {1'b0, rd_y};
    assign y_bot    = y_top + CMP_W'(SIZE - 1);
    assign scan_hit = rd_active && (y_top <= y_next_q) && (y_next_q <= y_bot);
    assign scan_row = COORD_W'(y_next_q - y_top);
    assign y_target = (pixel_y == PIX_Y_W'(V_TOTAL - 1)) ? '0 : ({1'b0, pixel_y} + CMP_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
            y_next_q   <= '0;
            shd_cnt_q  <= '0;
            act_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pixel_x == PIX_X_W'(H_ACTIVE)) begin
                        state_q    <= SCAN;
                        scan_idx_q <= '0;
                        y_next_q   <= y_target;
                        shd_cnt_q  <= '0;
                    end
                end
                SCAN: begin
                    if (pixel_x == '0) begin
                        state_q <= IDLE;
                    end else begin
                        if (scan_hit) begin
                            if (shd_cnt_q < CNT_W'(MAX_LINE)) begin
                                shd_x_q[IDX_W'(shd_cnt_q)]   <= rd_x;
                                shd_row_q[IDX_W'(shd_cnt_q)] <= scan_row;
                                shd_el_q[IDX_W'(shd_cnt_q)]  <= rd_el;
                                shd_cnt_q                    <= shd_cnt_q + CNT_W'(1);
                            end else begin
                                overflow_q <= 1'b1;
                            end
                        end
                        if (scan_idx_q == SLOT_W'(SLOTS - 1)) begin
                            state_q <= WAIT;
                        end else begin
                            scan_idx_q <= scan_idx_q + SLOT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (pixel_x == '0) begin
                        state_q   <= IDLE;
                        act_x_q   <= shd_x_q;
                        act_row_q <= shd_row_q;
                        act_el_q  <= shd_el_q;
                        act_cnt_q <= shd_cnt_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [MAX_LINE-1:0] draw_hit;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   address_d;

    for (genvar gi = 0; gi < MAX_LINE; gi++) begin : g_cmp
        logic [CMP_W-1:0] lo_x;
        logic [CMP_W-1:0] hi_x;
        assign lo_x         = {1'b0, act_x_q[gi]};
        assign hi_x         = lo_x + CMP_W'(SIZE - 1);
        assign draw_hit[gi] = (act_cnt_q > CNT_W'(gi)) && (lo_x <= pixel_x) && (pixel_x <= hi_x);
    end

    // Walk downward so the lowest buffer index (lowest slot) ends up the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = MAX_LINE - 1; i >= 0; i--) begin
            if (draw_hit[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

    assign address_d = (act_row_q[win_idx] * ADDR_W'(SIZE))
                     + ADDR_W'(pixel_x - {1'b0, act_x_q[win_idx]});

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            element_q <= '0;
            address_q <= '0;
        end else begin
            ready_q <= win_found;
            if (win_found) begin
                element_q <= act_el_q[win_idx];
                address_q <= address_d;
            end
        end
    end

    assign ready    = ready_q;
    assign element  = element_q;
    assign address  = address_q;
    assign overflow = overflow_q;

endmodule
